// File: rtl/conv_layer_sched.sv
// conv_layer_sched: layer-level sequencer for the convolution engine.
// For one configured layer it walks every (filter, input channel) pair. For each
// pass it presents start addresses and mode bits, pulses conv_en, and waits for
// the engine's STOP flag.
// Optional feature: define CONV_LAYER_SCHED_GLOBMAXP_EN to enable global max-pool mode
// (globmaxp_en driven from gmp, output stride of 1 per filter).
module conv_layer_sched #(
    parameter int unsigned SIZE_address_pix = 13,
    parameter int unsigned SIZE_address_wei = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [5:0]                  n_in,
    input  logic [5:0]                  n_filt,
    input  logic [4:0]                  matrix,
    input  logic [9:0]                  matrix2,
    input  logic [SIZE_address_pix-1:0] base_p,
    input  logic [SIZE_address_pix-1:0] base_zap,
    input  logic [SIZE_address_wei-1:0] base_w,
    input  logic                        gmp,
    input  logic                        STOP,
    output logic                        conv_en,
    output logic [SIZE_address_pix-1:0] memstartp,
    output logic [SIZE_address_pix-1:0] memstartzap,
    output logic [SIZE_address_wei-1:0] memstartw,
    output logic [4:0]                  lvl,
    output logic [1:0]                  slvl,
    output logic [2:0]                  num,
    output logic [4:0]                  filt,
    output logic                        bias,
    output logic                        globmaxp_en,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {StIdle, StSetup, StRun, StDrain, StFin} state_e;

    state_e state_q, state_d;
    logic [4:0] f_q, f_d;
    logic [4:0] l_q, l_d;
    logic       drain_q, drain_d;
    logic       run_first_q, run_first_d;
    logic       abort_hit;

    // Latched layer configuration
    logic [5:0]                  nin_q;
    logic [4:0]                  filt_q;
    logic [9:0]                  matrix2_q;
    logic [SIZE_address_pix-1:0] base_p_q;
    logic [SIZE_address_pix-1:0] base_zap_q;
    logic [SIZE_address_wei-1:0] base_w_q;
    logic                        gmp_q;

    // Registered outputs
    logic                        conv_en_q;
    logic [SIZE_address_pix-1:0] memstartp_q;
    logic [SIZE_address_pix-1:0] memstartzap_q;
    logic [SIZE_address_wei-1:0] memstartw_q;
    logic [4:0]                  lvl_q;
    logic [1:0]                  slvl_q;
    logic [2:0]                  num_q;
    logic                        bias_q;
    logic                        globmaxp_en_q;
    logic                        busy_q;
    logic                        done_q;

    logic        last_l;
    logic        last_f;
    logic [31:0] pix_off;
    logic [31:0] wei_off;
    logic [31:0] zap_off;

    // The side length is informational only; the caller supplies matrix2 directly
    logic unused_cfg;
`ifdef CONV_LAYER_SCHED_GLOBMAXP_EN
    assign unused_cfg = ^matrix;

    // Global max-pool request is captured with the rest of the configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            gmp_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            gmp_q <= gmp;
        end
    end
`else
    assign unused_cfg = ^{matrix, gmp};
    assign gmp_q      = 1'b0;
`endif

    assign last_l = ({1'b0, l_q} == (nin_q - 6'd1));
    assign last_f = (f_q == filt_q);

    // Per-pass address offsets, truncated to port width when registered
    always_comb begin
        pix_off = 32'(l_q) * 32'(matrix2_q);
        wei_off = 32'(f_q) * 32'(nin_q) + 32'(l_q);
        zap_off = gmp_q ? 32'(f_q) : 32'(f_q) * 32'(matrix2_q);
    end

    // Capture the layer configuration when a start is accepted; zero counts mean one
    always_ff @(posedge clk) begin
        if (rst) begin
            nin_q      <= 6'd0;
            filt_q     <= 5'd0;
            matrix2_q  <= 10'd0;
            base_p_q   <= '0;
            base_zap_q <= '0;
            base_w_q   <= '0;
        end else if (state_q == StIdle && start) begin
            nin_q      <= (n_in == 6'd0) ? 6'd1 : n_in;
            filt_q     <= (n_filt == 6'd0) ? 5'd0 : 5'(n_filt - 6'd1);
            matrix2_q  <= matrix2;
            base_p_q   <= base_p;
            base_zap_q <= base_zap;
            base_w_q   <= base_w;
        end
    end

    // State and loop-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            f_q         <= 5'd0;
            l_q         <= 5'd0;
            drain_q     <= 1'b0;
            run_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            l_q         <= l_d;
            drain_q     <= drain_d;
            run_first_q <= run_first_d;
        end
    end

    // Next-state logic: filter outer loop, channel inner loop, abort overrides all
    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        l_d         = l_q;
        drain_d     = drain_q;
        run_first_d = run_first_q;
        abort_hit   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    f_d     = 5'd0;
                    l_d     = 5'd0;
                end
            end
            StSetup: begin
                run_first_d = 1'b1;
                state_d     = StRun;
            end
            StRun: begin
                run_first_d = 1'b0;
                // STOP may be stale from the previous pass on the first RUN cycle
                if (!run_first_q && STOP) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end
            end
            StDrain: begin
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else if (!last_l) begin
                    l_d     = l_q + 5'd1;
                    state_d = StSetup;
                end else if (!last_f) begin
                    l_d     = 5'd0;
                    f_d     = f_q + 5'd1;
                    state_d = StSetup;
                end else begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (abort && (state_q == StSetup || state_q == StRun || state_q == StDrain)) begin
            abort_hit = 1'b1;
            state_d   = StIdle;
        end
    end

    // Output registers; pass addresses are loaded in SETUP and held through RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_en_q     <= 1'b0;
            memstartp_q   <= '0;
            memstartzap_q <= '0;
            memstartw_q   <= '0;
            lvl_q         <= 5'd0;
            slvl_q        <= 2'd0;
            num_q         <= 3'd0;
            bias_q        <= 1'b0;
            globmaxp_en_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            conv_en_q     <= (state_q == StRun) && !abort_hit;
            // Only the final-channel pass of a filter may use the pooled output layout
            globmaxp_en_q <= (state_q == StRun) && !abort_hit && gmp_q && bias_q;
            busy_q        <= (state_q != StIdle) && !abort_hit;
            done_q        <= (state_q == StFin);
            if (state_q == StSetup && !abort_hit) begin
                memstartp_q   <= base_p_q + SIZE_address_pix'(pix_off);
                memstartw_q   <= base_w_q + SIZE_address_wei'(wei_off);
                memstartzap_q <= base_zap_q + SIZE_address_pix'(zap_off);
                lvl_q         <= l_q;
                num_q         <= f_q[2:0];
                slvl_q        <= f_q[4:3];
                bias_q        <= last_l;
            end
        end
    end

    assign conv_en     = conv_en_q;
    assign memstartp   = memstartp_q;
    assign memstartzap = memstartzap_q;
    assign memstartw   = memstartw_q;
    assign lvl         = lvl_q;
    assign slvl        = slvl_q;
    assign num         = num_q;
    assign filt        = filt_q;
    assign bias        = bias_q;
    assign globmaxp_en = globmaxp_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/conv_layer_sched.md
# conv_layer_sched

Layer-level sequencer for the single convolution engine. For one configured layer it steps through every (output filter, input channel) pair and, for each pair, presents the engine's start addresses and mode bits. It then pulses the engine enable for one pass and waits for the engine's STOP, repeating until the layer is complete. It sits between the top-level network FSM, which issues one `start` per layer, and the convolution engine.

## Interface
Parameters:
- `SIZE_address_pix`, 13: pixel-memory address width.
- `SIZE_address_wei`, 9: weight-memory address width.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle request to run a layer; sampled only in IDLE.
- `abort`  in  1: abandon the layer; takes effect in any non-IDLE state.
- `n_in`  in  6: number of input channels, 1..32.
- `n_filt`  in  6: number of output filters, 1..32.
- `matrix`  in  5: feature-map side length.
- `matrix2`  in  10: `matrix*matrix`, supplied by the caller.
- `base_p`  in  SIZE_address_pix: input map base address.
- `base_zap`  in  SIZE_address_pix: output map base address.
- `base_w`  in  SIZE_address_wei: weight base address.
- `gmp`  in  1: global max-pool layer request.
- `STOP`  in  1: engine pass-complete flag; held high until `conv_en` drops.
- `conv_en`  out  1: engine enable.
- `memstartp`  out  SIZE_address_pix: engine input start address.
- `memstartzap`  out  SIZE_address_pix: engine output start address.
- `memstartw`  out  SIZE_address_wei: engine weight start address.
- `lvl`  out  5: input channel index of the current pass.
- `slvl`  out  2: filter index bits [4:3].
- `num`  out  3: filter index bits [2:0].
- `filt`  out  5: `n_filt-1`.
- `bias`  out  1: high on the last input channel of a filter.
- `globmaxp_en`  out  1: global max-pool mode to the engine.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse at the end of a layer.

## Operation
- Configuration inputs are latched on the cycle `start` is accepted. They are ignored afterwards until IDLE is reached again.
- Counters:
  - `f` runs 0..n_filt-1 as the outer loop.
  - `l` runs 0..n_in-1 as the inner loop.
- Per-pass outputs, registered in SETUP and held stable through RUN:
  - `memstartp = base_p + l*matrix2`
  - `memstartw = base_w + f*n_in + l`
  - `memstartzap = base_zap + f*matrix2`; when `globmaxp_en`=1, `base_zap + f` instead.
  - `lvl = l[4:0]`, `num = f[2:0]`, `slvl = f[4:3]`
  - `bias = (l == n_in-1)`
- Address arithmetic is unsigned and truncated to the port width; wrap-around is silent.
- States:
  - IDLE: on `start`, latch the configuration, clear `f` and `l`, go to SETUP.
  - SETUP (1 cycle): drive the addresses with `conv_en`=0, go to RUN.
  - RUN: `conv_en`=1. STOP is ignored on the first RUN cycle, because the engine may still hold it from the previous pass. Once STOP=1 is seen, go to DRAIN.
  - DRAIN (2 cycles): `conv_en`=0 so the engine clears STOP and its internal index. Then:
    - if `l < n_in-1`: increment `l`, go to SETUP;
    - else if `f < n_filt-1`: clear `l`, increment `f`, go to SETUP;
    - else go to FIN.
  - FIN (1 cycle): `done`=1, go to IDLE.
- `abort` from SETUP, RUN or DRAIN forces `conv_en`=0 and returns to IDLE on the next edge. No `done` is generated.
- `n_in`=0 or `n_filt`=0 at `start`: treated as 1.
- `start` while `busy`: ignored; the current layer is unaffected.
- `abort` and `start` in the same IDLE cycle: `start` wins.

## Timing
- Reset values:
  - state IDLE;
  - `conv_en`, `busy`, `done`, `bias`, `globmaxp_en` = 0;
  - all addresses, `lvl`, `slvl`, `num`, `filt` = 0.
- `rst` mid-layer: identical to the above; `conv_en` drops on that same edge.
- `start` at edge N: `busy`=1 at N+1, addresses valid at N+2, `conv_en`=1 at N+2.
- STOP first seen high at edge M: `conv_en`=0 at M+1, next `conv_en`=1 at M+4.
- Overhead per pass is 4 cycles beyond the engine run time (SETUP + DRAIN + the STOP sampling edge).
- `done` pulses one cycle after the final DRAIN. `busy` drops together with `done` falling.

## Configuration
- `CONV_LAYER_SCHED_GLOBMAXP_EN` defined:
  - `globmaxp_en` = latched `gmp`, and the `memstartzap` stride becomes 1 per filter.
  - `globmaxp_en` is asserted only in the RUN state of passes where `bias`=1, so partial-sum passes always write the full map.
- Macro undefined: `gmp` is ignored, `globmaxp_en` is tied to 0, and the stride is always `matrix2`.

## Test plan
- Basic sequence: n_in=2, n_filt=2, matrix=4, matrix2=16, base_p=0, base_w=0, base_zap=100; STOP model returns 20 cycles after `conv_en` rises.
  - Expect 4 passes with (memstartp, memstartw, memstartzap, lvl, bias) = (0,0,100,0,0), (16,1,100,1,1), (0,2,116,0,0), (16,3,116,1,1).
  - Expect exactly one `done`.
- Stale STOP: hold STOP high during the first RUN cycle of each pass. Expect no early exit from RUN, and `conv_en` low for exactly 3 cycles between passes.
- `abort` raised mid-RUN of pass 2: `conv_en`=0 and `busy`=0 on the next edge; `done` never pulses. A new `start` then begins again at f=0, l=0.
- `rst` asserted during DRAIN: all outputs return to their reset values on that edge. `start` during RUN: no effect on the pass sequence.
- Filter split: n_filt=12, n_in=1. Filter 9 drives num=1, slvl=1. `bias`=1 on every pass.
- With the macro defined, gmp=1, n_in=2, n_filt=3, base_zap=50:
  - `memstartzap` = 50, 51, 52 per filter;
  - `globmaxp_en`=1 only during the l=1 passes.
  - Without the macro, `globmaxp_en` stays 0 and the addresses step by `matrix2`.
